// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: debounced single-step, divided free-run and PC breakpoint halt.
// Latency: key press (first sampled low) to cpu_en is DEBOUNCE_CYCLES+3 clk cycles.
// Backpressure: none; presses arriving while an action is pending are simply dropped.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 5000000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_step_n,
  input  logic             key_run_n,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       pc,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int VW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [VW-1:0] DIV_LAST = VW'(RUN_DIV - 1);

  typedef enum logic [1:0] {PAUSED = 2'd0, RUN = 2'd1, BREAK = 2'd2} state_t;

  // Key index 0 is step, 1 is run/pause.
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, stable, stable_d, press, armed;
  logic [DW-1:0] dcnt [2];
  logic [1:0]    settle;
  logic          settle_done;

  state_t        state, state_nxt;
  logic [VW-1:0] div, div_nxt;
  logic          bp_skip, skip_nxt;
  logic          en_nxt;

  assign raw         = {key_run_n, key_step_n};
  assign settle_done = (settle == 2'd2);

  // Synchronise, debounce and edge-detect both keys. A key only becomes armed once the
  // synchronizer has flushed after reset and shows it released, so a key held through
  // reset is not reported until it is released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      stable   <= 2'b11;
      stable_d <= 2'b11;
      press    <= 2'b00;
      armed    <= 2'b00;
      settle   <= 2'd0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (!settle_done) settle <= settle + 2'd1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          dcnt[i]   <= '0;
          stable[i] <= sync2[i];
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
        if (settle_done && sync2[i]) armed[i] <= 1'b1;
        press[i] <= armed[i] & stable_d[i] & ~stable[i];
      end
    end
  end

  // Mode FSM next-state and pulse decision; run press always beats step press.
  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    skip_nxt  = bp_skip;
    en_nxt    = 1'b0;
    case (state)
      PAUSED: begin
        if (press[1]) begin
          state_nxt = RUN;
          div_nxt   = '0;
        end else if (press[0]) begin
          en_nxt = 1'b1;
        end
      end
      RUN: begin
        if (press[1]) begin
          state_nxt = PAUSED;
          div_nxt   = '0;
        end else if (div == DIV_LAST) begin
          div_nxt = '0;
          if (bp_en && (pc == bp_addr) && !bp_skip) begin
            state_nxt = BREAK;
          end else begin
            en_nxt   = 1'b1;
            skip_nxt = 1'b0;
          end
        end else begin
          div_nxt = div + VW'(1);
        end
      end
      BREAK: begin
        if (press[1]) begin
          state_nxt = RUN;
          div_nxt   = '0;
          skip_nxt  = 1'b1;
        end else if (press[0]) begin
          en_nxt    = 1'b1;
          state_nxt = PAUSED;
        end
      end
      default: state_nxt = PAUSED;
    endcase
  end

  // State, divider and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PAUSED;
      div        <= '0;
      bp_skip    <= 1'b0;
      cpu_en     <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_nxt;
      div        <= div_nxt;
      bp_skip    <= skip_nxt;
      cpu_en     <= en_nxt;
      running    <= (state_nxt == RUN);
      halted     <= (state_nxt == BREAK);
      step_count <= step_count + {{(CNT_W-1){1'b0}}, en_nxt};
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with short debounce and divider settings.
// A second narrow-counter, fast-divider instance exercises step_count wrap-around.
// Outputs are sampled 1 time unit after the rising edge or on the falling edge.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_step_n, key_run_n, bp_en;
  logic [7:0]  bp_addr, pc;
  logic        cpu_en, running, halted;
  logic [15:0] step_count;

  logic        w_run_n;
  logic        w_en, w_running, w_halted;
  logic [3:0]  w_count;

  int tests = 0;
  int fails = 0;
  int pulses = 0, wpulses = 0, consec = 0, cyc = 0, last_cyc = 0, gap = 0;
  logic prev_en = 1'b0, prev_w = 1'b0;

  always #5 clk = ~clk;

  assign pc = step_count[7:0];

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .key_step_n(key_step_n), .key_run_n(key_run_n),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .running(running), .halted(halted), .step_count(step_count)
  );

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(2), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .key_step_n(1'b1), .key_run_n(w_run_n),
    .bp_en(1'b0), .bp_addr(8'h00), .pc(8'h00),
    .cpu_en(w_en), .running(w_running), .halted(w_halted), .step_count(w_count)
  );

  // Pulse monitor: totals, spacing and back-to-back detection.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_en = 1'b0;
      prev_w  = 1'b0;
    end else begin
      if (cpu_en) begin
        pulses++;
        gap      = cyc - last_cyc;
        last_cyc = cyc;
        if (prev_en) consec++;
      end
      if (w_en) begin
        wpulses++;
        if (prev_w) consec++;
      end
      prev_en = cpu_en;
      prev_w  = w_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // which: 0 = step, 1 = run, 2 = both, 3 = run key of the wrap instance
  task automatic hold_key(input int which);
    if (which == 0 || which == 2) key_step_n = 1'b0;
    if (which == 1 || which == 2) key_run_n  = 1'b0;
    if (which == 3) w_run_n = 1'b0;
    repeat (10) tick();
    key_step_n = 1'b1;
    key_run_n  = 1'b1;
    w_run_n    = 1'b1;
    repeat (10) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    int p0, first_k, npulse;
    rst = 1'b1; key_step_n = 1'b1; key_run_n = 1'b1; w_run_n = 1'b1;
    bp_en = 1'b0; bp_addr = 8'h00;
    do_reset();
    chk("reset_outputs", {cpu_en, running, halted}, 3'b000);
    chk("reset_count", step_count, 0);

    // Short glitch: no event.
    p0 = pulses;
    key_step_n = 1'b0;
    repeat (3) tick();
    key_step_n = 1'b1;
    repeat (20) tick();
    chk("glitch_pulses", pulses - p0, 0);
    chk("glitch_count", step_count, 0);

    // Held step key: one pulse, DEBOUNCE+3 cycles after the first sampling edge.
    first_k = 0; npulse = 0;
    key_step_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (cpu_en) begin
        npulse++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("step_latency", first_k, 8);
    chk("step_single", npulse, 1);
    p0 = pulses;
    repeat (100) tick();
    chk("step_hold_nomore", pulses - p0, 0);
    chk("step_count1", step_count, 1);
    key_step_n = 1'b1;
    repeat (20) tick();
    chk("step_release", pulses - p0, 0);

    // Free run.
    do_reset();
    p0 = pulses;
    hold_key(1);
    chk("run_enter", running, 1);
    for (int i = 0; i < 100 && (pulses - p0) < 5; i++) tick();
    chk("run_count5", step_count, 5);
    chk("run_gap", gap, 8);
    key_run_n = 1'b0;
    for (int i = 0; i < 30 && running; i++) tick();
    chk("pause_enter", running, 0);
    key_run_n = 1'b1;
    npulse = pulses;
    repeat (40) tick();
    chk("pause_nopulse", pulses - npulse, 0);
    chk("pause_count", step_count, pulses - p0);

    // Breakpoint at pc 3.
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h03;
    hold_key(1);
    for (int i = 0; i < 200 && !halted; i++) tick();
    chk("bp_halted", {running, halted}, 2'b01);
    chk("bp_count", step_count, 3);
    p0 = pulses;
    repeat (30) tick();
    chk("bp_stays", pulses - p0, 0);
    hold_key(1);
    for (int i = 0; i < 20 && pulses == p0; i++) tick();
    chk("bp_resume_one", pulses - p0, 1);
    chk("bp_resume_count", step_count, 4);
    chk("bp_resume_state", {running, halted}, 2'b10);
    bp_addr = 8'h06;
    for (int i = 0; i < 200 && !halted; i++) tick();
    chk("bp2_count", step_count, 6);

    // Step out of BREAK.
    p0 = pulses;
    hold_key(0);
    chk("brk_step_pulse", pulses - p0, 1);
    chk("brk_step_count", step_count, 7);
    chk("brk_step_state", {running, halted}, 2'b00);

    // Simultaneous presses: run wins, no immediate pulse.
    p0 = pulses;
    key_step_n = 1'b0; key_run_n = 1'b0;
    repeat (12) tick();
    chk("both_running", running, 1);
    chk("both_nopulse", pulses - p0, 0);
    chk("both_count", step_count, 7);
    key_step_n = 1'b1; key_run_n = 1'b1;
    repeat (10) tick();

    // Reset during RUN.
    rst = 1'b1;
    tick();
    chk("rst_run_outputs", {cpu_en, running, halted}, 3'b000);
    chk("rst_run_count", step_count, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Counter wrap on the 4-bit instance.
    p0 = wpulses;
    hold_key(3);
    for (int i = 0; i < 200 && (wpulses - p0) < 15; i++) tick();
    chk("wrap_15", w_count, 15);
    for (int i = 0; i < 20 && (wpulses - p0) < 16; i++) tick();
    chk("wrap_0", w_count, 0);
    chk("no_back_to_back", consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
